uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive front end of the SOC's UART: takes the asynchronous RXD pin, recovers 8N1 frames at 115200 baud from the 25 MHz system clock, and queues the received bytes.
- Sits directly downstream of the RXD pin and upstream of the CPU's memory-mapped UART data register.
- The CPU pops bytes through a valid/ready handshake.
- Sticky framing and overrun flags are exposed for the status register.

Parameters:
- CLKS_PER_BIT, 217, system clocks per UART bit (25 MHz / 115200).
- FIFO_DEPTH, 4, number of received bytes buffered; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rxd  in  1  raw serial input; idle high; asynchronous to clk.
- rx_data  out  8  byte at the FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- err_clr  in  1  clears frame_err and overrun on the next clock edge.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - FSM in IDLE; FIFO empty; bit counter and clock counter at 0.
  - Synchronizer flops preset to 1.
- Input synchronizer: 2-flop chain on rxd, producing rxd_s. All decisions use rxd_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. cnt is the clock counter.
- IDLE: when rxd_s==0, set cnt=0 and go to START.
- START: when cnt==CLKS_PER_BIT/2-1 (107):
  - if rxd_s==0, set cnt=0 and go to DATA.
  - otherwise treat it as a glitch and return to IDLE; nothing is pushed and no flag is set.
- DATA: when cnt==CLKS_PER_BIT-1, sample rxd_s into shift[bitidx], LSB first.
  - After bitidx==7, go to STOP.
  - Sampling therefore occurs at mid-bit.
- STOP: when cnt==CLKS_PER_BIT-1, sample rxd_s:
  - rxd_s==1: push the byte and go to IDLE.
  - rxd_s==0: discard the byte, set frame_err, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s==1, then go to IDLE. This absorbs break conditions without generating false starts.
- Push latency: the byte is written on the stop-sample edge. rx_valid and rx_data update on that same edge when the FIFO was empty, i.e. 2 sync cycles plus about 9.5 bit periods after the start edge on the pin.
- FIFO: synchronous, show-ahead; rx_data is the head entry. Read and write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Push while full without a pop in the same cycle: the byte is dropped, FIFO contents are unchanged, and overrun is set.
- Push and pop in the same cycle while full: both are accepted; count is unchanged; no overrun.
- Push and pop in the same cycle while at count 1: the new byte becomes head the next cycle; rx_valid stays 1.
- Pop while empty: ignored.
- err_clr and a new error event in the same cycle: the flag remains set (set wins).
- Reset mid-frame: the FSM returns to IDLE immediately, the FIFO is flushed, flags are cleared. A frame in progress on rxd at release resynchronizes via WAIT_IDLE-style behaviour: after reset the FSM waits for rxd_s==1 for one sample before accepting a start bit.
- Tolerance: the start-bit deviation used by the SOC bench (start bit stretched by 1000 ns, about 25 clocks) must still decode correctly.

Decomposition:
- Package uart_pkg holds:
  - The rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Default constants: CLK_HZ=25_000_000, BAUD=115200, CLKS_PER_BIT=217.
- The FIFO is a natural sub-module, rx_fifo (parameter FIFO_DEPTH, width 8, with push, pop, full, empty). The top level holds the synchronizer, FSM, counters and flags.

Test Plan:
- Single byte: 0x34 framed at 217 clk/bit, then rx_ready=1 -> rx_valid rises about 2065 clocks after the start edge; rx_data=0x34; frame_err=0; overrun=0.
- Burst: 0x34, 0x35, 0x2A, 0x34, 0x32 sent back-to-back with rx_ready=0 -> FIFO holds 0x34, 0x35, 0x2A, 0x34; 0x32 is dropped; overrun=1. After 4 pops, rx_valid=0. err_clr -> overrun=0.
- Stretched start: start bit held 217+25 clocks, then data 0x2F -> 0x2F is received; no errors.
- Glitch: rxd low for 50 clocks, then high -> FSM returns to IDLE; no push; no flags.
- Framing: 0x39 with the stop bit low for 2 bit periods, then high, then a valid 0x30 -> frame_err=1; 0x39 is not queued; 0x30 is received correctly afterwards.
- Reset mid-frame: assert reset during DATA bit 3 of 0x33, release, then send 0x33 -> after release all outputs read 0; the next frame yields rx_data=0x33 with no errors.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding and default timing constants for UART RX.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int CLK_HZ       = 25_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_fifo.sv
// ============================================================================
// Module   : rx_fifo
// Brief    : Show-ahead synchronous FIFO; head entry visible on o_data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty   = (r_wp == r_rp);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wp[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with synchronizer, byte FIFO and sticky flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  import uart_pkg::*;

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_half = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_full = CW'(CLKS_PER_BIT - 1);

  rx_state_t     r_state;
  rx_state_t     w_next;
  logic          r_sync1;
  logic          r_rxd_s;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shift;
  logic          w_cnt_clr;
  logic          w_shift_en;
  logic          w_push;
  logic          w_ferr_set;
  logic          w_ovr_set;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    case (r_state)
      IDLE: begin
        // A line seen high once since reset is required before a start bit counts.
        if (!r_rxd_s && r_armed) begin
          w_next    = START;
          w_cnt_clr = 1'b1;
        end
      end
      START: begin
        if (r_cnt == c_half) begin
          w_cnt_clr = 1'b1;
          w_next    = r_rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == c_full) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bitidx == 3'd7) w_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == c_full) begin
          w_cnt_clr = 1'b1;
          if (r_rxd_s) begin
            w_push = 1'b1;
            w_next = IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_next     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (r_rxd_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      if (r_rxd_s) r_armed <= 1'b1;
      if (r_state != DATA) begin
        r_bitidx <= '0;
      end else if (w_shift_en) begin
        r_shift[r_bitidx] <= r_rxd_s;
        r_bitidx          <= r_bitidx + 3'd1;
      end
    end
  end

  assign w_pop     = rx_valid && rx_ready;
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign rx_valid  = !w_empty;

  // Set has priority over clear so a same-cycle error is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_ferr_set)   frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (w_ovr_set)    overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

  rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo using an expected-byte queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];

  always #20 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic send_byte(input logic [7:0] d, input int extra_start, input int stop_low_bits);
    rxd = 1'b0;
    repeat (CPB + extra_start) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low_bits > 0) begin
      rxd = 1'b0;
      repeat (CPB * stop_low_bits) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Pops n bytes, comparing each against the scoreboard head.
  task automatic drain(input int n, input string tag);
    logic [7:0] e;
    int         w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (rx_valid !== 1'b1 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (rx_valid !== 1'b1 || rx_data !== e) begin
        bad++;
        $display("FAIL %s_data[%0d]: got valid=%b data=%h, need valid=1 data=%h", tag, k, rx_valid, rx_data, e);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %b, need %b", name, got, need);
    end
  endtask

  task automatic test_reset();
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b ovr=%b, need all 0", rx_data, rx_valid, frame_err, overrun);
    end
  endtask

  task automatic test_single();
    int lat = 0;
    exp_q.push_back(8'h34);
    fork
      send_byte(8'h34, 0, 0);
      begin
        while (rx_valid !== 1'b1 && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    total++;
    if (lat < 2055 || lat > 2075) begin
      bad++;
      $display("FAIL single_latency: got %0d clocks, need about 2063", lat);
    end
    check_bit("single_ferr", frame_err, 1'b0);
    check_bit("single_ovr", overrun, 1'b0);
    drain(1, "single");
    check_bit("single_empty", rx_valid, 1'b0);
  endtask

  task automatic test_burst();
    logic [7:0] b [5];
    b[0] = 8'h34; b[1] = 8'h35; b[2] = 8'h2A; b[3] = 8'h34; b[4] = 8'h32;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(b[i]);
      send_byte(b[i], 0, 0);
    end
    check_bit("burst_ovr_set", overrun, 1'b1);
    check_bit("burst_ferr", frame_err, 1'b0);
    drain(4, "burst");
    check_bit("burst_empty", rx_valid, 1'b0);
    pulse_clr();
    check_bit("burst_ovr_clr", overrun, 1'b0);
  endtask

  task automatic test_stretched();
    exp_q.push_back(8'h2F);
    send_byte(8'h2F, 25, 0);
    drain(1, "stretch");
    check_bit("stretch_ferr", frame_err, 1'b0);
    check_bit("stretch_ovr", overrun, 1'b0);
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (CPB * 3) @(negedge clk);
    check_bit("glitch_valid", rx_valid, 1'b0);
    check_bit("glitch_ferr", frame_err, 1'b0);
    check_bit("glitch_ovr", overrun, 1'b0);
  endtask

  task automatic test_framing();
    send_byte(8'h39, 0, 2);
    check_bit("frame_ferr_set", frame_err, 1'b1);
    check_bit("frame_no_push", rx_valid, 1'b0);
    exp_q.push_back(8'h30);
    send_byte(8'h30, 0, 0);
    drain(1, "frame_next");
    check_bit("frame_ovr", overrun, 1'b0);
    pulse_clr();
    check_bit("frame_ferr_clr", frame_err, 1'b0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h33;
    // Leave a byte queued and a sticky flag set so the reset has work to undo.
    send_byte(8'h31, 0, 0);
    send_byte(8'h55, 0, 2);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = d[3];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got data=%h valid=%b ferr=%b ovr=%b, need all 0", rx_data, rx_valid, frame_err, overrun);
    end
    reset = 1'b0;
    repeat (CPB) @(negedge clk);
    check_bit("midreset_release_valid", rx_valid, 1'b0);
    exp_q.push_back(8'h33);
    send_byte(8'h33, 0, 0);
    drain(1, "midreset");
    check_bit("midreset_ferr", frame_err, 1'b0);
    check_bit("midreset_ovr", overrun, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (CPB) @(negedge clk);
    test_single();
    test_burst();
    test_stretched();
    test_glitch();
    test_framing();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
